// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART bus master: register map,
// STATUS bit positions, FSM states and bus request bundle.
package uart_bus_pkg;

    localparam logic [2:0] A_RXDATA  = 3'd0;
    localparam logic [2:0] A_TXDATA  = 3'd1;
    localparam logic [2:0] A_STATUS  = 3'd2;
    localparam logic [2:0] A_CONTROL = 3'd3;

    localparam int ST_PE   = 0;
    localparam int ST_FE   = 1;
    localparam int ST_ROE  = 3;
    localparam int ST_TRDY = 6;
    localparam int ST_RRDY = 7;

    typedef enum logic [2:0] {
        S_INIT,
        S_POLL,
        S_ACCESS,
        S_DECIDE,
        S_GAP
    } state_e;

    typedef enum logic {
        ACC_RD,
        ACC_WR
    } acc_e;

    typedef struct packed {
        logic        go;
        acc_e        acc;
        logic [2:0]  addr;
        logic [15:0] data;
    } req_t;

    function automatic logic status_err(input logic [15:0] s);
        return s[ST_PE] | s[ST_FE] | s[ST_ROE];
    endfunction

endpackage

// File: rtl/uart_byte_buf.sv
// Single-entry byte holding register; a load always wins over a
// same-cycle consume so a fresh byte is never lost.
module uart_byte_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= 8'h00;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Register-port initiator for the UART: polls STATUS and turns
// core byte streams into RXDATA/TXDATA/STATUS accesses.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned POLL_GAP     = 4,
    parameter logic [15:0] CTRL_INIT    = 16'h0000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_begintransfer,
    output logic        av_read_n,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    output logic [7:0]  err_count
);

    localparam logic [1:0] LAT      = 2'(READ_LATENCY);
    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    state_e     state;
    acc_e       acc_q;
    req_t       req;
    logic [1:0] lat_cnt;
    logic [7:0] gap_cnt;
    logic       init_done;
    logic       st_rrdy;
    logic       st_trdy;
    logic       st_err;
    logic       rd_done;
    logic       rx_load;
    logic       tx_pop;
    logic       tx_full;
    logic [7:0] tx_byte;

    assign av_begintransfer = av_chipselect;
    assign tx_ready = init_done & ~tx_full;
    assign rd_done  = (state == S_ACCESS) && (acc_q == ACC_RD)
                   && (lat_cnt == LAT);
    assign rx_load  = rd_done && (av_address == A_RXDATA);
    assign tx_pop   = (state == S_ACCESS) && (acc_q == ACC_WR)
                   && (av_address == A_TXDATA);

    uart_byte_buf u_tx_buf (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .load      (tx_valid & tx_ready),
        .load_data (tx_data),
        .valid     (tx_full),
        .ready     (tx_pop),
        .data      (tx_byte)
    );

    uart_byte_buf u_rx_buf (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .load      (rx_load),
        .load_data (av_readdata[7:0]),
        .valid     (rx_valid),
        .ready     (rx_ready),
        .data      (rx_data)
    );

    // Next strobe to launch; defaults to a STATUS poll.
    always_comb begin
        req = '{go: 1'b0, acc: ACC_RD, addr: A_STATUS, data: 16'h0000};
        unique case (state)
            S_INIT:   req = '{1'b1, ACC_WR, A_CONTROL, CTRL_INIT};
            S_POLL:   req.go = 1'b1;
            S_ACCESS: req.go = rx_load;
            S_DECIDE: begin
                if (st_rrdy && !rx_valid)
                    req = '{1'b1, ACC_RD, A_RXDATA, 16'h0000};
                else if (st_err)
                    req = '{1'b1, ACC_WR, A_STATUS, 16'h0000};
                else if (st_trdy && tx_full)
                    req = '{1'b1, ACC_WR, A_TXDATA, {8'h00, tx_byte}};
                else
                    req.go = (POLL_GAP == 0);
            end
            S_GAP:    req.go = (gap_cnt == GAP_LAST);
            default:  req.go = 1'b0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state         <= S_INIT;
            acc_q         <= ACC_RD;
            lat_cnt       <= 2'd0;
            gap_cnt       <= 8'd0;
            init_done     <= 1'b0;
            st_rrdy       <= 1'b0;
            st_trdy       <= 1'b0;
            st_err        <= 1'b0;
            err_count     <= 8'h00;
            av_address    <= 3'd0;
            av_chipselect <= 1'b0;
            av_read_n     <= 1'b1;
            av_write_n    <= 1'b1;
            av_writedata  <= 16'h0000;
        end else if (req.go) begin
            av_chipselect <= 1'b1;
            av_read_n     <= (req.acc != ACC_RD);
            av_write_n    <= (req.acc != ACC_WR);
            av_address    <= req.addr;
            av_writedata  <= req.data;
            acc_q         <= req.acc;
            lat_cnt       <= 2'd0;
            state         <= S_ACCESS;
        end else begin
            av_chipselect <= 1'b0;
            av_read_n     <= 1'b1;
            av_write_n    <= 1'b1;
            unique case (state)
                S_ACCESS: begin
                    if (acc_q == ACC_WR) begin
                        if (av_address == A_CONTROL)
                            init_done <= 1'b1;
                        state <= S_POLL;
                    end else if (lat_cnt == LAT) begin
                        st_rrdy <= av_readdata[ST_RRDY];
                        st_trdy <= av_readdata[ST_TRDY];
                        st_err  <= status_err(av_readdata);
                        if (status_err(av_readdata) && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        state <= S_DECIDE;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_DECIDE: begin
                    gap_cnt <= 8'd0;
                    state   <= S_GAP;
                end
                S_GAP:    gap_cnt <= gap_cnt + 8'd1;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with a behavioural UART
// register slave per instance (READ_LATENCY 1 and 3).
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        tx_valid1, tx_ready1, rx_valid1, rx_ready1;
    logic [7:0]  tx_data1, rx_data1, err1;
    logic [2:0]  addr1;
    logic        cs1, bt1, read_n1, write_n1;
    logic [15:0] wdata1, rdata1;

    logic        tx_ready3, rx_valid3;
    logic [7:0]  rx_data3, err3;
    logic [2:0]  addr3;
    logic        cs3, bt3, read_n3, write_n3;
    logic [15:0] wdata3, rdata3;

    logic [15:0] stat1, rxd1, stat3, rxd3;
    logic [3:0]  pv1 = '0;
    logic [3:0]  pv3 = '0;
    logic [2:0]  ra1 = '0;
    logic [2:0]  ra3 = '0;
    bit          hold;
    int          err_wr;
    int          rx_rds;
    logic [18:0] exp_wr[$];
    logic [2:0]  order[$];
    int          polls1[$];
    int          polls3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_bus_master #(.READ_LATENCY(1), .POLL_GAP(4), .CTRL_INIT(16'h0000)) dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
        .rx_valid(rx_valid1), .rx_ready(rx_ready1), .rx_data(rx_data1),
        .av_address(addr1), .av_chipselect(cs1), .av_begintransfer(bt1),
        .av_read_n(read_n1), .av_write_n(write_n1), .av_writedata(wdata1),
        .av_readdata(rdata1), .err_count(err1)
    );

    uart_bus_master #(.READ_LATENCY(3), .POLL_GAP(4), .CTRL_INIT(16'h0000)) dut3 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .tx_valid(1'b0), .tx_ready(tx_ready3), .tx_data(8'h00),
        .rx_valid(rx_valid3), .rx_ready(1'b0), .rx_data(rx_data3),
        .av_address(addr3), .av_chipselect(cs3), .av_begintransfer(bt3),
        .av_read_n(read_n3), .av_write_n(write_n3), .av_writedata(wdata3),
        .av_readdata(rdata3), .err_count(err3)
    );

    // Slave read data is only valid in cycle strobe+READ_LATENCY.
    always @(posedge clk) begin
        pv1 <= {pv1[2:0], cs1 & ~read_n1};
        pv3 <= {pv3[2:0], cs3 & ~read_n3};
        if (cs1) ra1 <= addr1;
        if (cs3) ra3 <= addr3;
    end
    assign rdata1 = !pv1[0] ? 16'hFFFF : ra1 == 3'd0 ? rxd1 : ra1 == 3'd2 ? stat1 : 16'h0000;
    assign rdata3 = !pv3[2] ? 16'hFFFF : ra3 == 3'd0 ? rxd3 : ra3 == 3'd2 ? stat3 : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && cs1) begin
            check("begintransfer", 32'(bt1), 32'd1);
            check("one_strobe", 32'(read_n1 ^ write_n1), 32'd1);
            if (!write_n1) begin
                if (hold && addr1 == 3'd2) begin
                    err_wr++;
                end else begin
                    checks++;
                    assert (exp_wr.size() > 0) else begin
                        errors++;
                        $error("FAIL wr_unexpected: observed addr %0d data %h expected none", addr1, wdata1);
                    end
                    if (exp_wr.size() > 0)
                        check("wr_addr_data", 32'({addr1, wdata1}), 32'(exp_wr.pop_front()));
                    if (addr1 != 3'd3) order.push_back(addr1);
                    if (addr1 == 3'd2) stat1 &= ~16'h000B;
                end
            end else if (addr1 == 3'd2) begin
                polls1.push_back(cyc);
            end else begin
                order.push_back(addr1);
                rx_rds++;
                stat1 &= ~16'h0080;
            end
        end
        if (rst_n && cs3 && !read_n3) begin
            if (addr3 == 3'd2) polls3.push_back(cyc);
            else stat3 &= ~16'h0080;
        end
    end

    initial begin
        int n0;
        bit seen;
        rst_n = 1'b0; hold = 0; err_wr = 0; rx_rds = 0;
        tx_valid1 = 1'b0; tx_data1 = 8'h00; rx_ready1 = 1'b0;
        stat1 = 16'h0000; rxd1 = 16'h0000; stat3 = 16'h0000; rxd3 = 16'h0000;
        repeat (3) tick();
        check("rst_tx_ready", 32'(tx_ready1), 32'd0);
        check("rst_rx_valid", 32'(rx_valid1), 32'd0);
        check("rst_rx_data", 32'(rx_data1), 32'd0);
        check("rst_cs", 32'(cs1), 32'd0);
        check("rst_bt", 32'(bt1), 32'd0);
        check("rst_read_n", 32'(read_n1), 32'd1);
        check("rst_write_n", 32'(write_n1), 32'd1);
        check("rst_addr", 32'(addr1), 32'd0);
        check("rst_wdata", 32'(wdata1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);

        exp_wr.push_back({3'd3, 16'h0000});
        rst_n = 1'b1;
        tick();
        check("init_first_write", 32'(exp_wr.size()), 32'd0);
        check("init_no_poll_first", 32'(polls1.size()), 32'd0);
        tick();
        check("init_tx_ready", 32'(tx_ready1), 32'd1);
        check("init_err", 32'(err1), 32'd0);

        stat1 = 16'h0040;
        exp_wr.push_back({3'd1, 16'h00A5});
        tx_valid1 = 1'b1; tx_data1 = 8'hA5;
        tick();
        tx_valid1 = 1'b0;
        check("tx_ready_drop", 32'(tx_ready1), 32'd0);
        for (int i = 0; i < 20 && exp_wr.size() != 0; i++) tick();
        check("tx_write_2polls", 32'(exp_wr.size()), 32'd0);
        check("tx_ready_in_strobe", 32'(tx_ready1), 32'd0);
        tick();
        check("tx_ready_rise", 32'(tx_ready1), 32'd1);
        stat1 = 16'h0000;

        rxd1 = 16'h003C; stat1 = 16'h0080;
        for (int i = 0; i < 20 && !rx_valid1; i++) tick();
        check("rx_valid", 32'(rx_valid1), 32'd1);
        check("rx_data", 32'(rx_data1), 32'h3C);
        n0 = rx_rds;
        rxd1 = 16'h0055; stat1 = 16'h0080;
        repeat (30) tick();
        check("rx_hold_no_read", 32'(rx_rds - n0), 32'd0);
        check("rx_data_stable", 32'(rx_data1), 32'h3C);
        rx_ready1 = 1'b1;
        tick();
        rx_ready1 = 1'b0;
        check("rx_consumed", 32'(rx_valid1), 32'd0);
        for (int i = 0; i < 20 && !rx_valid1; i++) tick();
        check("rx_second_data", 32'({rx_valid1, rx_data1}), 32'h155);
        rx_ready1 = 1'b1;
        tick();
        rx_ready1 = 1'b0;

        tx_valid1 = 1'b1; tx_data1 = 8'h5E;
        tick();
        tx_valid1 = 1'b0;
        order.delete();
        exp_wr.push_back({3'd2, 16'h0000});
        exp_wr.push_back({3'd1, 16'h005E});
        rxd1 = 16'h0077; stat1 = 16'h00C9;
        for (int i = 0; i < 20 && !rx_valid1; i++) tick();
        check("prio_err_first_poll", 32'(err1), 32'd1);
        check("prio_rx_data", 32'({rx_valid1, rx_data1}), 32'h177);
        for (int i = 0; i < 30 && exp_wr.size() != 0; i++) tick();
        check("prio_writes_done", 32'(exp_wr.size()), 32'd0);
        check("prio_order_len", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            check("prio_order0_rxdata", 32'(order[0]), 32'd0);
            check("prio_order1_status", 32'(order[1]), 32'd2);
            check("prio_order2_txdata", 32'(order[2]), 32'd1);
        end
        check("prio_err_total", 32'(err1), 32'd2);
        rx_ready1 = 1'b1;
        tick();
        rx_ready1 = 1'b0;

        stat1 = 16'h0000;
        repeat (10) tick();
        polls1.delete(); polls3.delete();
        repeat (40) tick();
        check("gap_polls_seen1", 32'(polls1.size() >= 3), 32'd1);
        check("gap_polls_seen3", 32'(polls3.size() >= 3), 32'd1);
        if (polls1.size() >= 3) begin
            check("gap_rl1_a", 32'(polls1[1] - polls1[0]), 32'd7);
            check("gap_rl1_b", 32'(polls1[2] - polls1[1]), 32'd7);
        end
        if (polls3.size() >= 3) begin
            check("gap_rl3_a", 32'(polls3[1] - polls3[0]), 32'd9);
            check("gap_rl3_b", 32'(polls3[2] - polls3[1]), 32'd9);
        end
        rxd3 = 16'h00C3; stat3 = 16'h0080;
        for (int i = 0; i < 40 && !rx_valid3; i++) tick();
        check("rl3_rx_data", 32'({rx_valid3, rx_data3}), 32'h1C3);
        check("rl3_err_none", 32'(err3), 32'd0);

        stat1 = 16'h0040;
        tx_valid1 = 1'b1; tx_data1 = 8'h99;
        tick();
        tx_valid1 = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk);
            #2;
            seen = cs1 && !write_n1 && addr1 == 3'd1;
        end
        check("rst_tx_strobe_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_write_n", 32'(write_n1), 32'd1);
        check("rst_mid_cs", 32'(cs1), 32'd0);
        check("rst_mid_tx_ready", 32'(tx_ready1), 32'd0);
        exp_wr.push_back({3'd3, 16'h0000});
        hold = 1; err_wr = 0; stat1 = 16'h0001;
        repeat (2) tick();
        check("rst_err_cleared", 32'(err1), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3000 && err_wr < 300; i++) tick();
        check("err_polls_done", 32'(err_wr >= 300), 32'd1);
        check("err_saturated", 32'(err1), 32'hFF);
        check("reinit_write", 32'(exp_wr.size()), 32'd0);
        stat1 = 16'h0000;
        repeat (10) tick();
        hold = 0;
        repeat (20) tick();
        check("err_hold_sat", 32'(err1), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
